// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the feature-map address sequencers (write and read
// side): default map geometry, opcode-to-slot layout and the sequencer FSM
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

  // Map geometry: MAP_DIM x MAP_DIM words per feature slot, power of two.
  localparam int WB_MAP_DIM    = 64;
  // Maximum channels written by one layer opcode.
  localparam int WB_NUM_CH     = 3;
  // Slot index used by opcode 0.
  localparam int WB_FIRST_IDX  = 3;
  // Opcodes 0..SINGLE_OPS-1 write channel 0 only.
  localparam int WB_SINGLE_OPS = 16;
  // The next MULTI_OPS opcodes write all NUM_CH channels.
  localparam int WB_MULTI_OPS  = 16;
  // Parking slot; a channel decoded here is disabled.
  localparam int WB_IDLE_IDX   = 67;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_slot_decode.sv
// -----------------------------------------------------------------------------
// wb_slot_decode
// Combinational opcode decode: for every channel k yields the feature slot
// index, its enable (slot != IDLE_IDX) and its base word address
// (idx * MAP_DIM^2, truncated to ADDR_W).
// Ports:
//   i_opcode : layer opcode
//   o_en     : per-channel enable, bit k = channel k
//   o_base   : per-channel base address, channel k at [k*ADDR_W +: ADDR_W]
// -----------------------------------------------------------------------------
module wb_slot_decode
  import wb_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int ADDR_W     = 19,
  parameter int IDX_W      = 7,
  parameter int MAP_DIM    = WB_MAP_DIM,
  parameter int NUM_CH     = WB_NUM_CH,
  parameter int FIRST_IDX  = WB_FIRST_IDX,
  parameter int SINGLE_OPS = WB_SINGLE_OPS,
  parameter int MULTI_OPS  = WB_MULTI_OPS,
  parameter int IDLE_IDX   = WB_IDLE_IDX
) (
  input  logic [OPCODE_W-1:0]      i_opcode,
  output logic [NUM_CH-1:0]        o_en,
  output logic [NUM_CH*ADDR_W-1:0] o_base
);

  localparam logic [IDX_W-1:0] IDLE_IDX_V = IDX_W'(IDLE_IDX);
  localparam longint           MAP_WORDS  = longint'(MAP_DIM) * longint'(MAP_DIM);

  // The parking slot must be addressable, otherwise base + pix could carry
  // past the top of the address space.
  if (longint'(IDLE_IDX) * MAP_WORDS >= (longint'(1) << ADDR_W)) begin : g_range_err
    $error("wb_slot_decode: IDLE_IDX*MAP_DIM^2 does not fit in ADDR_W bits");
  end

  logic [31:0]      w_op;
  logic [IDX_W-1:0] w_idx [NUM_CH];

  assign w_op = 32'(i_opcode);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      w_idx[k] = IDLE_IDX_V;
      if (w_op < 32'(SINGLE_OPS)) begin
        if (k == 0) w_idx[k] = IDX_W'(32'(FIRST_IDX) + w_op);
      end else if (w_op < 32'(SINGLE_OPS + MULTI_OPS)) begin
        w_idx[k] = IDX_W'(32'(FIRST_IDX + SINGLE_OPS)
                          + (w_op - 32'(SINGLE_OPS)) * 32'(NUM_CH) + 32'(k));
      end
      o_en[k] = (w_idx[k] != IDLE_IDX_V);
      // Product is taken modulo 2^ADDR_W, matching a truncated full product.
      o_base[k*ADDR_W +: ADDR_W] = ADDR_W'(w_idx[k]) * ADDR_W'(MAP_WORDS);
    end
  end

endmodule

// File: rtl/wb_addr_seq.sv
// -----------------------------------------------------------------------------
// wb_addr_seq
// Write-back address sequencer. On a start request it latches the layer
// opcode, decodes the destination slots, then streams one write address per
// accepted beat, pixel-major / channel-minor, across all enabled channels.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_start, i_opcode : one-cycle layer request and its opcode (IDLE only)
//   o_busy            : sequence in progress (LOAD, RUN, DONE)
//   o_valid, i_ready  : beat handshake
//   o_addr, o_ch      : write address and channel of the current beat
//   o_last            : final beat of the layer
//   o_done, o_err     : completion pulse; error when no channel is enabled
//   o_base            : registered per-channel base addresses
// -----------------------------------------------------------------------------
module wb_addr_seq
  import wb_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int ADDR_W     = 19,
  parameter int IDX_W      = 7,
  parameter int MAP_DIM    = WB_MAP_DIM,
  parameter int NUM_CH     = WB_NUM_CH,
  parameter int FIRST_IDX  = WB_FIRST_IDX,
  parameter int SINGLE_OPS = WB_SINGLE_OPS,
  parameter int MULTI_OPS  = WB_MULTI_OPS,
  parameter int IDLE_IDX   = WB_IDLE_IDX
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic                                           i_start,
  input  logic [OPCODE_W-1:0]                            i_opcode,
  output logic                                           o_busy,
  output logic                                           o_valid,
  input  logic                                           i_ready,
  output logic [ADDR_W-1:0]                              o_addr,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_ch,
  output logic                                           o_last,
  output logic                                           o_done,
  output logic                                           o_err,
  output logic [NUM_CH*ADDR_W-1:0]                       o_base
);

  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int               PIX_W   = $clog2(MAP_DIM * MAP_DIM);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  wb_state_e               r_state, w_next;
  logic [OPCODE_W-1:0]     r_op;
  logic [NUM_CH*ADDR_W-1:0] r_base, w_base;
  logic [NUM_CH-1:0]       r_en, w_en;
  logic [PIX_W-1:0]        r_pix, w_pix_inc;
  logic [CH_W-1:0]         r_ch;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_err;

  logic [CH_W-1:0]         w_lo_new;   // lowest enabled channel of the fresh decode
  logic [CH_W-1:0]         w_lo;       // lowest enabled channel of the loaded set
  logic [CH_W-1:0]         w_hi;       // highest enabled channel of the loaded set
  logic [CH_W-1:0]         w_nxt;      // next enabled channel above r_ch
  logic                    w_has_nxt;
  logic                    w_accept;
  logic                    w_last;

  wb_slot_decode #(
    .OPCODE_W  (OPCODE_W),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W),
    .MAP_DIM   (MAP_DIM),
    .NUM_CH    (NUM_CH),
    .FIRST_IDX (FIRST_IDX),
    .SINGLE_OPS(SINGLE_OPS),
    .MULTI_OPS (MULTI_OPS),
    .IDLE_IDX  (IDLE_IDX)
  ) u_decode (
    .i_opcode(r_op),
    .o_en    (w_en),
    .o_base  (w_base)
  );

  // Channel selection. Descending scans let the last hit be the lowest match.
  always_comb begin
    w_lo_new = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_en[k]) w_lo_new = CH_W'(k);
    end
  end

  always_comb begin
    w_lo      = '0;
    w_hi      = '0;
    w_nxt     = '0;
    w_has_nxt = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (r_en[k]) w_lo = CH_W'(k);
      if (r_en[k] && (k > int'(r_ch))) begin
        w_nxt     = CH_W'(k);
        w_has_nxt = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_en[k]) w_hi = CH_W'(k);
    end
  end

  assign w_pix_inc = r_pix + 1'b1;
  assign w_accept  = (r_state == ST_RUN) && i_ready;
  assign w_last    = (r_state == ST_RUN) && (r_pix == PIX_MAX) && (r_ch == w_hi);

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state and status outputs.
  always_comb begin
    w_next  = r_state;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_done  = 1'b0;
    o_err   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy = 1'b1;
        w_next = (w_en == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_last  = w_last;
        if (w_accept && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        o_err  = r_err;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: opcode latch, base/enable registers, pixel/channel counters and
  // the registered beat address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op   <= '0;
      r_base <= '0;
      r_en   <= '0;
      r_pix  <= '0;
      r_ch   <= '0;
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) r_op <= i_opcode;
        end
        ST_LOAD: begin
          r_base <= w_base;
          r_en   <= w_en;
          r_pix  <= '0;
          r_ch   <= w_lo_new;
          // r_base is not loaded yet, so the first address comes from the decode.
          r_addr <= w_base[w_lo_new*ADDR_W +: ADDR_W];
          r_err  <= (w_en == '0);
        end
        ST_RUN: begin
          if (w_accept && !w_last) begin
            if (w_has_nxt) begin
              r_ch   <= w_nxt;
              r_addr <= r_base[w_nxt*ADDR_W +: ADDR_W] + ADDR_W'(r_pix);
            end else begin
              r_ch   <= w_lo;
              r_pix  <= w_pix_inc;
              r_addr <= r_base[w_lo*ADDR_W +: ADDR_W] + ADDR_W'(w_pix_inc);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_addr = r_addr;
  assign o_ch   = r_ch;
  assign o_base = r_base;

endmodule

// File: tb/tb_wb_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_wb_addr_seq
// Self-checking bench for wb_addr_seq. A behavioural model turns each opcode
// into the full list of expected beats; a compare process checks every beat
// the DUT presents, and the sequence tasks check timing, status pulses and
// a set of hand-computed addresses.
// -----------------------------------------------------------------------------
module tb_wb_addr_seq;

  localparam int OPCODE_W = 6;
  localparam int ADDR_W   = 19;
  localparam int NUM_CH   = 3;
  localparam int MAP_DIM  = 64;
  localparam int WORDS    = MAP_DIM * MAP_DIM;

  typedef struct {
    int unsigned addr;
    int unsigned ch;
    bit          last;
  } beat_t;

  logic                      i_clk;
  logic                      i_rst;
  logic                      i_start;
  logic [OPCODE_W-1:0]       i_opcode;
  logic                      o_busy;
  logic                      o_valid;
  logic                      i_ready;
  logic [ADDR_W-1:0]         o_addr;
  logic [1:0]                o_ch;
  logic                      o_last;
  logic                      o_done;
  logic                      o_err;
  logic [NUM_CH*ADDR_W-1:0]  o_base;

  wb_addr_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_opcode(i_opcode),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_addr  (o_addr),
    .o_ch    (o_ch),
    .o_last  (o_last),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_base  (o_base)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       exp_q[$];
  int unsigned exp_base [NUM_CH];
  int          exp_beats;
  bit          exp_err;
  int          beats_seen;
  int unsigned got_addr [4];
  int unsigned got_last_addr;
  int unsigned got_last_ch;
  int          ready_mode;   // 0: always ready, 1: random, 2: stall beat 1
  int          stall_left;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot indices straight from the opcode rules, then the
  // beat list as a pixel loop wrapped around a channel loop.
  function automatic void model_layer(input int op);
    int idx [NUM_CH];
    int hi;
    for (int k = 0; k < NUM_CH; k++) idx[k] = 67;
    if (op < 16) idx[0] = 3 + op;
    else if (op < 32) for (int k = 0; k < NUM_CH; k++) idx[k] = 3 + 16 + (op - 16) * NUM_CH + k;
    hi = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_base[k] = (idx[k] * WORDS) % (1 << ADDR_W);
      if (idx[k] != 67) hi = k;
    end
    exp_q.delete();
    for (int p = 0; p < WORDS; p++)
      for (int k = 0; k < NUM_CH; k++)
        if (idx[k] != 67) begin
          beat_t b;
          b.addr = exp_base[k] + p;
          b.ch   = k;
          b.last = (p == WORDS - 1) && (k == hi);
          exp_q.push_back(b);
        end
    exp_beats = exp_q.size();
    exp_err   = (hi < 0);
  endfunction

  // Ready driver, updated just after each rising edge.
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0: i_ready = 1'b1;
      1: i_ready = ($urandom_range(0, 7) != 0);
      default: begin
        if (o_valid && beats_seen == 1 && stall_left > 0) begin
          i_ready = 1'b0;
          stall_left--;
        end else begin
          i_ready = 1'b1;
        end
      end
    endcase
  end

  // Beat compare process, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", o_valid, 0);
      end else begin
        check("beat_addr", o_addr, exp_q[0].addr);
        check("beat_ch",   o_ch,   exp_q[0].ch);
        check("beat_last", o_last, exp_q[0].last);
        if (i_ready) begin
          if (beats_seen < 4) got_addr[beats_seen] = o_addr;
          got_last_addr = o_addr;
          got_last_ch   = o_ch;
          void'(exp_q.pop_front());
          beats_seen++;
        end
      end
      if (ready_mode == 2 && !i_ready) check("bp_hold_addr", o_addr, 81920);
    end
  end

  task automatic pulse_start(input int op);
    @(posedge i_clk);
    #1;
    i_start  = 1'b1;
    i_opcode = OPCODE_W'(op);
    @(negedge i_clk);
    check("busy_before_load", o_busy, 0);
    @(posedge i_clk);
    #1;
    i_start  = 1'b0;
    i_opcode = OPCODE_W'($urandom);
  endtask

  task automatic run_layer(input int op, input int mode, input int inject_beat,
                           input bit inject_done, output int done_n);
    int first_n, last_n, inj_n, budget;
    bit injected;
    model_layer(op);
    beats_seen  = 0;
    ready_mode  = mode;
    first_n     = -1;
    last_n      = -1;
    done_n      = -1;
    inj_n       = -1;
    injected    = 1'b0;
    budget      = exp_beats * 8 + 16;
    pulse_start(op);
    for (int n = 1; n <= budget; n++) begin
      @(negedge i_clk);
      if (n == 1) begin
        check("load_busy",  o_busy,  1);
        check("load_valid", o_valid, 0);
      end
      if (o_valid && first_n < 0) first_n = n;
      if (o_valid && i_ready && o_last) last_n = n;
      if (injected && n == inj_n + 1) i_start = 1'b0;
      if (inject_beat > 0 && !injected && beats_seen >= inject_beat) begin
        i_start  = 1'b1;
        i_opcode = 6'd2;
        injected = 1'b1;
        inj_n    = n;
      end
      if (o_done) begin
        done_n = n;
        break;
      end
    end
    i_start = 1'b0;
    if (done_n < 0) begin
      check("done_timeout", o_done, 1);
      return;
    end
    if (exp_beats > 0) begin
      check("first_beat_latency", first_n, 2);
      check("done_after_last", done_n, last_n + 1);
    end else begin
      check("err_done_latency", done_n, 2);
    end
    check("done_err",       o_err,        exp_err);
    check("done_valid",     o_valid,      0);
    check("done_busy",      o_busy,       1);
    check("beats_left",     exp_q.size(), 0);
    check("beat_count",     beats_seen,   exp_beats);
    for (int k = 0; k < NUM_CH; k++)
      check("base_reg", o_base[k*ADDR_W +: ADDR_W], exp_base[k]);
    if (inject_done) begin
      i_start  = 1'b1;
      i_opcode = 6'd16;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    check("idle_busy", o_busy, 0);
    check("idle_done", o_done, 0);
    check("idle_err",  o_err,  0);
  endtask

  initial begin
    int dn;
    int rnd_op;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_opcode   = '0;
    i_ready    = 1'b1;
    ready_mode = 0;
    stall_left = 0;
    beats_seen = 0;
    repeat (3) @(negedge i_clk);
    check("rst_busy",  o_busy,  0);
    check("rst_valid", o_valid, 0);
    check("rst_addr",  o_addr,  0);
    check("rst_ch",    o_ch,    0);
    check("rst_last",  o_last,  0);
    check("rst_done",  o_done,  0);
    check("rst_err",   o_err,   0);
    check("rst_base",  o_base,  0);
    i_rst = 1'b0;

    // Opcode 5: single channel, start on the DONE cycle must be ignored.
    run_layer(5, 0, 0, 1'b1, dn);
    check("op5_base0",  o_base[0 +: ADDR_W],        32768);
    check("op5_base1",  o_base[ADDR_W +: ADDR_W],   274432);
    check("op5_base2",  o_base[2*ADDR_W +: ADDR_W], 274432);
    check("op5_first",  got_addr[0], 32768);
    check("op5_last",   got_last_addr, 36863);
    check("op5_beats",  beats_seen, 4096);

    // Opcode 16: three channels, channel-minor order.
    run_layer(16, 0, 0, 1'b0, dn);
    check("op16_b0", got_addr[0], 77824);
    check("op16_b1", got_addr[1], 81920);
    check("op16_b2", got_addr[2], 86016);
    check("op16_b3", got_addr[3], 77825);
    check("op16_last", got_last_addr, 90111);
    check("op16_last_ch", got_last_ch, 2);
    check("op16_beats", beats_seen, 12288);

    // Opcode 31: top of the slot range.
    run_layer(31, 0, 0, 1'b0, dn);
    check("op31_first", got_addr[0], 262144);
    check("op31_last", got_last_addr, 274431);
    check("op31_last_ch", got_last_ch, 2);

    // Opcode 40: nothing enabled, error completion.
    run_layer(40, 0, 0, 1'b0, dn);
    check("op40_done_cycle", dn, 2);
    check("op40_beats", beats_seen, 0);

    // Backpressure on beat 1 of opcode 16.
    stall_left = 3;
    run_layer(16, 2, 0, 1'b0, dn);
    check("bp_stall_used", stall_left, 0);
    check("bp_b1", got_addr[1], 81920);
    check("bp_b2", got_addr[2], 86016);

    // Opcode 0 with a start for opcode 2 injected mid-run.
    run_layer(0, 0, 100, 1'b0, dn);
    check("op0_first", got_addr[0], 12288);
    check("op0_last", got_last_addr, 16383);

    // Reset in the middle of a run.
    model_layer(7);
    beats_seen = 0;
    ready_mode = 0;
    pulse_start(7);
    for (int n = 0; n < 200 && beats_seen < 50; n++) @(negedge i_clk);
    check("rst_wait_beats", beats_seen >= 50, 1);
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_busy",  o_busy,  0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_addr",  o_addr,  0);
    check("mid_rst_ch",    o_ch,    0);
    check("mid_rst_last",  o_last,  0);
    check("mid_rst_done",  o_done,  0);
    check("mid_rst_base",  o_base,  0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    // Fresh start after reset, random backpressure.
    run_layer(7, 1, 0, 1'b0, dn);
    check("op7_first", got_addr[0], 40960);
    check("op7_last", got_last_addr, 45055);

    // One random opcode under random backpressure.
    rnd_op = $urandom_range(0, 47);
    run_layer(rnd_op, 1, 0, 1'b0, dn);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_addr_seq.md
Name: wb_addr_seq

Overview:
- Write-back address sequencer for feature-map stores.
- Per layer opcode, decodes up to NUM_CH destination feature-map slots, each MAP_DIM x MAP_DIM words.
- Emits a stream of write addresses under valid/ready: pixel-major, channel-minor.
- Sits between the layer controller (start/opcode) and the feature-memory write port.
- Generalises the fixed 3-channel, 64x64 combinational base-address decode: parametrised channel count and map size, plus sequencing, backpressure and error reporting.

Parameters:
- OPCODE_W, 6: opcode width.
- ADDR_W, 19: feature-memory word address width.
- IDX_W, 7: feature slot index width.
- MAP_DIM, 64: map height = width, power of two.
- NUM_CH, 3: maximum channels written per opcode.
- FIRST_IDX, 3: slot index of opcode 0.
- SINGLE_OPS, 16: opcodes 0..SINGLE_OPS-1 write channel 0 only.
- MULTI_OPS, 16: opcodes SINGLE_OPS..SINGLE_OPS+MULTI_OPS-1 write all NUM_CH channels.
- IDLE_IDX, 67: parking slot; a channel decoded to IDLE_IDX is disabled.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_start, input, 1: one-cycle request; i_opcode is sampled on the same cycle.
- i_opcode, input, OPCODE_W: layer opcode.
- o_busy, output, 1: high from the cycle after an accepted start through the DONE state.
- o_valid, output, 1: o_addr/o_ch/o_last are valid.
- i_ready, input, 1: consumer accepts the beat.
- o_addr, output, ADDR_W: write address.
- o_ch, output, clog2(NUM_CH) (min 1): channel of the current beat.
- o_last, output, 1: final beat of the layer.
- o_done, output, 1: one-cycle pulse at layer completion.
- o_err, output, 1: one-cycle pulse together with o_done when the opcode enables no channel.
- o_base, output, NUM_CH*ADDR_W: registered base addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. All counters and base registers clear.
- Decode, with op = latched opcode:
  - op < SINGLE_OPS: idx0 = FIRST_IDX + op; other channels = IDLE_IDX.
  - SINGLE_OPS <= op < SINGLE_OPS+MULTI_OPS: idx_k = FIRST_IDX + SINGLE_OPS + (op - SINGLE_OPS)*NUM_CH + k.
  - Any other op: all channels = IDLE_IDX.
  - base_k = idx_k * MAP_DIM * MAP_DIM, truncated to ADDR_W. An elaboration check requires IDLE_IDX*MAP_DIM^2 < 2^ADDR_W.
  - en_k = (idx_k != IDLE_IDX).
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: i_start=1 latches the opcode; next state LOAD.
  - LOAD (1 cycle): registers base_k/en_k into o_base. Clears pix=0 and ch to the lowest enabled channel. If no channel is enabled, goes to DONE with the error flag set; otherwise goes to RUN.
  - RUN: o_valid=1 and o_addr = base_ch + pix, a registered output.
    - A beat is accepted on o_valid & i_ready.
    - On acceptance, ch advances to the next enabled channel. After the highest enabled channel it wraps to the lowest enabled channel and pix increments.
    - o_last=1 when pix = MAP_DIM^2-1 and ch is the highest enabled channel. Accepting that beat moves the FSM to DONE.
  - DONE (1 cycle): o_done=1, and o_err=1 if the error flag is set. o_valid=0. Next state IDLE.
- Latency:
  - First beat is valid 2 cycles after i_start (start, LOAD, then RUN).
  - With i_ready held high, one beat per cycle: total beats = MAP_DIM^2 * popcount(en).
- Backpressure: while o_valid=1 and i_ready=0, o_addr/o_ch/o_last hold stable. o_valid never drops before acceptance.
- i_start outside IDLE is ignored, with no effect on the current sequence. i_start on the DONE cycle is also ignored.
- pix is a clog2(MAP_DIM^2)-bit counter. The sum base+pix never carries past ADDR_W, given the elaboration check.
- i_rst asserted mid-RUN: immediate return to the reset state. The in-flight beat is dropped and o_valid is 0 while reset is asserted.

Decomposition:
- Shared package (wb_pkg): MAP_DIM, NUM_CH, FIRST_IDX, SINGLE_OPS, MULTI_OPS and IDLE_IDX defaults, plus the FSM state encoding. These are shared with the read-side address sequencer.
- One sub-module, wb_slot_decode: the combinational opcode-to-{idx_k, en_k, base_k} decode for all NUM_CH channels. The sequencer instantiates it once.

Test Plan:
- Opcode 5, i_ready=1 (defaults):
  - o_base ch0 = 8*4096 = 32768; ch1/ch2 = 67*4096.
  - 4096 beats, o_ch=0, o_addr 32768..36863.
  - o_last on the final beat; o_done one cycle later; o_err=0.
- Opcode 16:
  - Beat order: 77824 (ch0), 81920 (ch1), 86016 (ch2), 77825, ...
  - Final beat is 90111 on ch2 with o_last; 12288 beats total.
- Opcode 31: first beat 262144, final beat 274431 (ch2). Verifies the top of range.
- Opcode 40: no o_valid, o_done and o_err both pulse 2 cycles after start, o_busy then returns to 0.
- Backpressure: opcode 16, i_ready low for 3 cycles on beat 1. o_addr holds 81920 with o_valid=1; the sequence resumes with no skipped or duplicated beat.
- Start and reset robustness:
  - i_start with opcode 2 mid-run of opcode 0: ignored, addresses continue 12288+pix.
  - i_rst mid-RUN: all outputs 0 immediately.
  - A fresh start after reset begins at pix 0.
